// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch front end: jump encodings,
// reset/NOP defaults and the IF/ID record layout.
package fetch_stage_pkg;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_JR   = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // Redirect targets are word addresses; the low two bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// 32-bit event counter that sticks at all-ones, with a synchronous active-low clear.
module sat_counter (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count <= '0;
    end else if (en && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Pipeline front end: program counter, next-PC arbitration and the IF/ID register,
// plus stall/flush performance counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  input  logic        i_pc_keep,
  input  logic        i_IF_ID_keep,
  input  logic        i_IF_ID_flush,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic [1:0]  i_jump,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_IF_ID_instr,
  output logic [31:0] o_IF_ID_pc_plus4,
  output logic        o_IF_ID_valid,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt
);

  localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  if_id_t      if_id;

  assign o_imem_addr = pc;
  assign pc_plus4    = pc + 32'd4;

  // A taken branch in EX outranks a stall: everything younger is discarded.
  always_comb begin
    next_pc = pc_plus4;
    if (i_branch_taken) begin
      next_pc = align_word(i_branch_target);
    end else if (i_pc_keep) begin
      next_pc = pc;
    end else begin
      case (i_jump)
        JUMP_NONE: next_pc = pc_plus4;
        JUMP_J:    next_pc = align_word(i_jump_target);
        JUMP_JR:   next_pc = align_word(i_jr_target);
        default:   next_pc = pc_plus4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc    <= RESET_PC;
      if_id <= BUBBLE;
    end else begin
      pc <= next_pc;
      if (i_branch_taken || (!i_IF_ID_keep && i_IF_ID_flush)) begin
        if_id <= BUBBLE;
      end else if (!i_IF_ID_keep) begin
        if_id <= '{instr: i_imem_data, pc_plus4: pc_plus4, valid: 1'b1};
      end
    end
  end

  assign o_IF_ID_instr    = if_id.instr;
  assign o_IF_ID_pc_plus4 = if_id.pc_plus4;
  assign o_IF_ID_valid    = if_id.valid;

  sat_counter u_stall_cnt (
    .clk     (clk),
    .clear_n (reset),
    .en      (i_pc_keep),
    .count   (o_stall_cnt)
  );

  // A flush that collides with an IF/ID hold is not a real flush.
  sat_counter u_flush_cnt (
    .clk     (clk),
    .clear_n (reset),
    .en      (i_IF_ID_flush & ~i_IF_ID_keep),
    .count   (o_flush_cnt)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a cycle model pushes expected state per
// driven cycle; the sampled DUT state is popped and compared one edge later.
module tb_fetch_stage;

  localparam int          W      = 161;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_data;
  logic        i_pc_keep;
  logic        i_IF_ID_keep;
  logic        i_IF_ID_flush;
  logic        i_branch_taken;
  logic [31:0] i_branch_target;
  logic [1:0]  i_jump;
  logic [31:0] i_jump_target;
  logic [31:0] i_jr_target;
  logic [31:0] o_IF_ID_instr;
  logic [31:0] o_IF_ID_pc_plus4;
  logic        o_IF_ID_valid;
  logic [31:0] o_stall_cnt;
  logic [31:0] o_flush_cnt;

  // clock / reset
  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .o_imem_addr      (o_imem_addr),
    .i_imem_data      (i_imem_data),
    .i_pc_keep        (i_pc_keep),
    .i_IF_ID_keep     (i_IF_ID_keep),
    .i_IF_ID_flush    (i_IF_ID_flush),
    .i_branch_taken   (i_branch_taken),
    .i_branch_target  (i_branch_target),
    .i_jump           (i_jump),
    .i_jump_target    (i_jump_target),
    .i_jr_target      (i_jr_target),
    .o_IF_ID_instr    (o_IF_ID_instr),
    .o_IF_ID_pc_plus4 (o_IF_ID_pc_plus4),
    .o_IF_ID_valid    (o_IF_ID_valid),
    .o_stall_cnt      (o_stall_cnt),
    .o_flush_cnt      (o_flush_cnt)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [31:0]  m_pc, m_instr, m_pc4, m_stall, m_flush;
  logic         m_valid;
  int           n_cmp = 0;
  int           n_err = 0;
  bit           skip_cnt = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // driver: one clock cycle of stimulus, model update, and compare
  task automatic step(input logic rst_n, input logic pc_keep, input logic if_keep,
                      input logic flush, input logic br, input logic [31:0] br_t,
                      input logic [1:0] jmp, input logic [31:0] j_t,
                      input logic [31:0] jr_t, input logic [31:0] data);
    logic [W-1:0] e;
    logic [31:0]  n_pc;
    @(negedge clk);
    reset           = rst_n;
    i_pc_keep       = pc_keep;
    i_IF_ID_keep    = if_keep;
    i_IF_ID_flush   = flush;
    i_branch_taken  = br;
    i_branch_target = br_t;
    i_jump          = jmp;
    i_jump_target   = j_t;
    i_jr_target     = jr_t;
    i_imem_data     = data;
    if (!rst_n) begin
      m_pc = RST_PC; m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
      m_stall = '0; m_flush = '0;
    end else begin
      if (br)                n_pc = br_t & ~32'h3;
      else if (pc_keep)      n_pc = m_pc;
      else if (jmp == 2'b01) n_pc = j_t & ~32'h3;
      else if (jmp == 2'b10) n_pc = jr_t & ~32'h3;
      else                   n_pc = m_pc + 32'd4;
      if (br || (!if_keep && flush)) begin
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
      end else if (!if_keep) begin
        m_instr = data; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      m_stall = sat_inc(m_stall, pc_keep);
      m_flush = sat_inc(m_flush, flush && !if_keep);
      m_pc    = n_pc;
    end
    exp_q.push_back({m_pc, m_instr, m_pc4, m_valid, m_stall, m_flush});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pc",       o_imem_addr,            e[160:129]);
    check("instr",    o_IF_ID_instr,          e[128:97]);
    check("pc_plus4", o_IF_ID_pc_plus4,       e[96:65]);
    check("valid",    {31'b0, o_IF_ID_valid}, {31'b0, e[64]});
    if (!skip_cnt) begin
      check("stall_cnt", o_stall_cnt, e[63:32]);
      check("flush_cnt", o_flush_cnt, e[31:0]);
    end
  endtask

  initial begin
    reset = 1'b0; i_pc_keep = 0; i_IF_ID_keep = 0; i_IF_ID_flush = 0;
    i_branch_taken = 0; i_branch_target = '0; i_jump = 2'b00;
    i_jump_target = '0; i_jr_target = '0; i_imem_data = '0;

    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h1111_1111);
    step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h2222_2222);
    check("tp_rst_pc", o_imem_addr, 32'h0040_0000);
    check("tp_rst_valid", {31'b0, o_IF_ID_valid}, 32'h0);

    step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h2008_0005);
    check("tp_first_instr", o_IF_ID_instr, 32'h2008_0005);
    check("tp_first_pc4", o_IF_ID_pc_plus4, 32'h0040_0004);
    check("tp_first_pc", o_imem_addr, 32'h0040_0004);
    step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h2009_0007);

    // stall both PC and IF/ID for two cycles at 0x0040_0008
    step(1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 32'hDEAD_0001);
    step(1, 1, 1, 0, 0, 0, 2'b00, 0, 0, 32'hDEAD_0002);
    check("tp_stall_pc", o_imem_addr, 32'h0040_0008);
    check("tp_stall_instr", o_IF_ID_instr, 32'h2009_0007);
    check("tp_stall_cnt", o_stall_cnt, 32'd2);

    step(1, 0, 0, 1, 0, 0, 2'b10, 32'h0040_0300, 32'h0040_0100, 32'h0800_0040);
    check("tp_jr_pc", o_imem_addr, 32'h0040_0100);
    check("tp_jr_valid", {31'b0, o_IF_ID_valid}, 32'h0);
    check("tp_jr_flush_cnt", o_flush_cnt, 32'd1);

    step(1, 1, 1, 0, 1, 32'h0040_0040, 2'b00, 0, 0, 32'h1234_5678);
    check("tp_br_pc", o_imem_addr, 32'h0040_0040);
    check("tp_br_valid", {31'b0, o_IF_ID_valid}, 32'h0);
    check("tp_br_stall_cnt", o_stall_cnt, 32'd3);

    // jump held off by a stall, then taken
    step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0810_0080);
    step(1, 1, 1, 0, 0, 0, 2'b01, 32'h0040_0202, 0, 32'h0810_0080);
    check("jump_keep_pc", o_imem_addr, 32'h0040_0044);
    step(1, 0, 0, 1, 0, 0, 2'b01, 32'h0040_0202, 0, 32'h0810_0080);
    check("jump_pc", o_imem_addr, 32'h0040_0200);

    // PC wrap at the top of the address space; branch target low bits dropped
    step(1, 0, 0, 0, 1, 32'hFFFF_FFFF, 2'b00, 0, 0, 32'h0);
    check("wrap_setup_pc", o_imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'hCAFE_F00D);
    check("tp_wrap_pc", o_imem_addr, 32'h0);
    check("tp_wrap_pc4", o_IF_ID_pc_plus4, 32'h0);
    check("tp_wrap_valid", {31'b0, o_IF_ID_valid}, 32'h1);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 40) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
           $urandom, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
    end

    // saturation: park both counters just below the top, then count past it
    step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0);
    force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
    force dut.u_flush_cnt.count = 32'hFFFF_FFFE;
    skip_cnt = 1'b1;
    step(1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 32'h0);
    release dut.u_stall_cnt.count;
    release dut.u_flush_cnt.count;
    skip_cnt = 1'b0;
    m_stall = 32'hFFFF_FFFF;
    m_flush = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 0, 2'b00, 0, 0, 32'h0);
    check("tp_sat_stall", o_stall_cnt, 32'hFFFF_FFFF);
    check("tp_sat_flush", o_flush_cnt, 32'hFFFF_FFFF);

    // reset while stalling and flushing
    step(0, 1, 1, 1, 0, 0, 2'b01, 32'h0000_1000, 0, 32'h0);
    check("tp_rst2_pc", o_imem_addr, RST_PC);
    check("tp_rst2_stall", o_stall_cnt, 32'h0);
    check("tp_rst2_flush", o_flush_cnt, 32'h0);
    check("tp_rst2_valid", {31'b0, o_IF_ID_valid}, 32'h0);
    step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h2008_0005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Front end of the five-stage pipeline and the consumer of the hazard unit's control outputs. Owns the program counter and the IF/ID pipeline register, and applies keep (stall), flush and redirect requests each cycle. Arbitrates EX-stage branch redirects and ID-stage jump redirects against stalls. Keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on a flush.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- o_imem_addr  out  32  instruction fetch address; combinational copy of PC.
- i_imem_data  in  32  instruction word for o_imem_addr, valid in the same cycle.
- i_pc_keep  in  1  hold PC this cycle.
- i_IF_ID_keep  in  1  hold IF/ID contents this cycle.
- i_IF_ID_flush  in  1  replace IF/ID contents with a bubble.
- i_branch_taken  in  1  branch resolved taken in EX.
- i_branch_target  in  32  EX branch target.
- i_jump  in  2  ID jump type: 00 none, 01 j/jal, 10 jr/jalr, 11 reserved (treated as none).
- i_jump_target  in  32  j/jal target computed in ID.
- i_jr_target  in  32  forwarded register value for jr/jalr.
- o_IF_ID_instr  out  32  registered instruction.
- o_IF_ID_pc_plus4  out  32  registered PC+4 of that instruction.
- o_IF_ID_valid  out  1  0 marks a bubble.
- o_stall_cnt  out  32  cycles with i_pc_keep=1, saturating.
- o_flush_cnt  out  32  cycles with i_IF_ID_flush=1 and no keep, saturating.

## Operation
- Next PC priority (highest first): i_branch_taken -> i_branch_target; i_pc_keep -> PC; i_jump=01 -> i_jump_target; i_jump=10 -> i_jr_target; else PC+4.
- A taken branch beats a stall: the instruction being stalled in ID is younger than the branch and is discarded.
- IF/ID priority: i_branch_taken -> bubble; i_IF_ID_keep -> hold; i_IF_ID_flush -> bubble; else load {i_imem_data, PC+4, valid=1}.
- Bubble means instr=NOP_INSTR, pc_plus4=0, valid=0.
- A jump with i_pc_keep=1 does not redirect; the jump is re-presented in the next cycle, and the held IF/ID keeps it valid.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). Targets are used as given; bits [1:0] are forced to 0.
- Counters increment by 1 per qualifying cycle and stick at 32'hFFFF_FFFF.

## Timing
- Reset: PC=RESET_PC, IF/ID = bubble, both counters=0. Reset wins over every other input, including mid-stall and mid-flush.
- The first valid IF/ID contents appear one cycle after reset deasserts.
- All redirects take effect at the next rising edge: 1-cycle redirect latency.
- Jump penalty is 1 bubble. Taken-branch penalty is 2 bubbles; the ID/EX bubble is outside this block.
- o_imem_addr changes only on clock edges.

## Structure
- Shared pipeline package holds: jump-type constants (JUMP_NONE/JUMP_J/JUMP_JR), NOP_INSTR default, RESET_PC default, and the IF/ID record fields.
- One natural sub-module: sat_counter (32-bit, enable, synchronous active-low clear), instantiated twice.
- The next-PC mux and the IF/ID register stay in fetch_stage.

## Test plan
- Reset then release with i_imem_data=32'h2008_0005 -> cycle 1: IF/ID instr=32'h2008_0005, pc_plus4=32'h0040_0004, valid=1; PC=32'h0040_0004.
- i_pc_keep=i_IF_ID_keep=1 for 2 cycles at PC=32'h0040_0008 -> PC and IF/ID unchanged for 2 cycles; o_stall_cnt=2.
- i_jump=10, i_jr_target=32'h0040_0100, i_IF_ID_flush=1 -> next PC=32'h0040_0100, IF/ID valid=0, o_flush_cnt increments by 1.
- i_branch_taken=1 with i_pc_keep=1 and i_IF_ID_keep=1, target 32'h0040_0040 -> PC=32'h0040_0040, IF/ID bubble; o_stall_cnt still increments.
- PC=32'hFFFF_FFFC, no control inputs -> next PC=0, pc_plus4=0, valid=1.
- Reset asserted during a stall, with counters preloaded to 32'hFFFF_FFFF (saturation checked first) -> PC=RESET_PC, IF/ID bubble, counters=0.
